// File: rtl/bus_arbiter.sv
// Two-master ADS bus arbiter with round-robin tie break and a dead turnaround on every handover.
// Optional hold limit with forced revoke: define ARB_TIMEOUT_EN.
module bus_arbiter #(
   parameter int TURNAROUND = 2,
   parameter int MAX_HOLD   = 64,
   parameter int CNT_W      = 7
) (
   input  logic clk,
   input  logic rst,
   input  logic req1,
   input  logic req2,
   output logic grant1,
   output logic grant2,
   output logic master_select,
   output logic bus_busy,
   output logic timeout_err
);

   typedef enum logic [1:0] {IDLE, GNT1, GNT2, TURN} state_e;

   localparam logic [CNT_W-1:0] TURN_LAST = CNT_W'(TURNAROUND - 1);

   if (TURNAROUND < 1 || MAX_HOLD < 2 || (2 ** CNT_W) <= TURNAROUND || (2 ** CNT_W) <= MAX_HOLD)
   begin : g_bad_params
      $error("bus_arbiter: illegal TURNAROUND/MAX_HOLD/CNT_W combination");
   end

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             last1_q, last1_d;   // 1: master 1 owned the bus last
   logic             grant1_q, grant1_d;
   logic             grant2_q, grant2_d;
   logic             msel_q, msel_d;
   logic             busy_q, busy_d;
   logic             tout_q, tout_d;

   function automatic state_e arbitrate(input logic r1, input logic r2, input logic last1);
      if (r1 && r2) return last1 ? GNT2 : GNT1;
      if (r1)       return GNT1;
      if (r2)       return GNT2;
      return IDLE;
   endfunction

   always_comb begin
      // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
      state_d = state_q;
      cnt_d   = cnt_q;
      last1_d = last1_q;
      tout_d  = 1'b0;

      case (state_q)
         IDLE: state_d = arbitrate(req1, req2, last1_q);
         GNT1: begin
            if (!req1) begin
               state_d = TURN;
               last1_d = 1'b1;
               cnt_d   = '0;
            end
`ifdef ARB_TIMEOUT_EN
            else if (cnt_q == CNT_W'(MAX_HOLD - 1)) begin
               state_d = TURN;
               last1_d = 1'b1;
               cnt_d   = '0;
               tout_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
`endif
         end
         GNT2: begin
            if (!req2) begin
               state_d = TURN;
               last1_d = 1'b0;
               cnt_d   = '0;
            end
`ifdef ARB_TIMEOUT_EN
            else if (cnt_q == CNT_W'(MAX_HOLD - 1)) begin
               state_d = TURN;
               last1_d = 1'b0;
               cnt_d   = '0;
               tout_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
`endif
         end
         TURN: begin
            if (cnt_q == TURN_LAST) state_d = arbitrate(req1, req2, last1_q);
            else                    cnt_d   = cnt_q + 1'b1;
         end
         default: state_d = IDLE;
      endcase

      // A fresh ownership always starts its hold count from zero.
      if ((state_d == GNT1 || state_d == GNT2) && state_d != state_q) cnt_d = '0;

      grant1_d = (state_d == GNT1);
      grant2_d = (state_d == GNT2);
      busy_d   = grant1_d | grant2_d;
      msel_d   = grant1_d ? 1'b1 : (grant2_d ? 1'b0 : msel_q);
   end

   // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         last1_q  <= 1'b0;
         grant1_q <= 1'b0;
         grant2_q <= 1'b0;
         msel_q   <= 1'b1;
         busy_q   <= 1'b0;
         tout_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         last1_q  <= last1_d;
         grant1_q <= grant1_d;
         grant2_q <= grant2_d;
         msel_q   <= msel_d;
         busy_q   <= busy_d;
         tout_q   <= tout_d;
      end
   end

   assign grant1        = grant1_q;
   assign grant2        = grant2_q;
   assign master_select = msel_q;
   assign bus_busy      = busy_q;
   assign timeout_err   = tout_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: per-cycle expected outputs are queued as stimulus is
// driven and compared after each rising edge.
module tb_bus_arbiter;

   localparam int TA = 2;
   localparam int MH = 8;
   localparam int CW = 7;

   // Output vector order: {grant1, grant2, master_select, bus_busy, timeout_err}
   localparam logic [4:0] RST_V = 5'b00100;  // reset / idle or gap after master 1
   localparam logic [4:0] GAP2  = 5'b00000;  // idle or gap after master 2
   localparam logic [4:0] G1    = 5'b10110;
   localparam logic [4:0] G2    = 5'b01010;
   localparam logic [4:0] TOUT2 = 5'b00001;  // revoke edge of master 2

   typedef struct packed {
      logic       rst;
      logic       r1;
      logic       r2;
      logic [4:0] exp;
   } vec_t;

   logic clk = 1'b0;
   logic rst, req1, req2;
   logic grant1, grant2, master_select, bus_busy, timeout_err;

   logic [4:0] exp_q[$];
   int vectors = 0;
   int miscompares = 0;

   bus_arbiter #(.TURNAROUND(TA), .MAX_HOLD(MH), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .req1(req1), .req2(req2),
      .grant1(grant1), .grant2(grant2), .master_select(master_select),
      .bus_busy(bus_busy), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   function automatic logic [4:0] obs();
      return {grant1, grant2, master_select, bus_busy, timeout_err};
   endfunction

   task automatic step(input vec_t v);
      rst  = v.rst;
      req1 = v.r1;
      req2 = v.r2;
      exp_q.push_back(v.exp);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      vec_t v[$];
      logic [4:0] want;
      v.push_back('{1'b1, 1'b1, 1'b1, RST_V});
      v.push_back('{1'b1, 1'b0, 1'b0, RST_V});
      foreach (v[i]) begin
         step(v[i]);
         want = exp_q.pop_front();
         vectors++;
         if (obs() !== want) begin
            $display("FAIL reset[%0d]: got %b want %b", i, obs(), want);
            miscompares++;
         end
      end
   endtask

   task automatic test_grant_latency();
      vec_t v[$];
      logic [4:0] want;
      v.push_back('{1'b0, 1'b0, 1'b0, RST_V});
      v.push_back('{1'b0, 1'b0, 1'b0, RST_V});
      v.push_back('{1'b0, 1'b1, 1'b0, G1});
      v.push_back('{1'b0, 1'b1, 1'b0, G1});
      v.push_back('{1'b0, 1'b0, 1'b0, RST_V});
      v.push_back('{1'b0, 1'b0, 1'b0, RST_V});
      v.push_back('{1'b0, 1'b0, 1'b0, RST_V});
      foreach (v[i]) begin
         step(v[i]);
         want = exp_q.pop_front();
         vectors++;
         if (obs() !== want) begin
            $display("FAIL grant_latency[%0d]: got %b want %b", i, obs(), want);
            miscompares++;
         end
      end
   endtask

   task automatic test_tie_handover();
      vec_t v[$];
      logic [4:0] want;
      v.push_back('{1'b1, 1'b0, 1'b0, RST_V});
      for (int i = 0; i < 3; i++) v.push_back('{1'b0, 1'b1, 1'b1, G1});
      v.push_back('{1'b0, 1'b0, 1'b1, RST_V});
      v.push_back('{1'b0, 1'b0, 1'b1, RST_V});
      v.push_back('{1'b0, 1'b0, 1'b1, G2});
      v.push_back('{1'b0, 1'b0, 1'b1, G2});
      v.push_back('{1'b0, 1'b0, 1'b0, GAP2});
      v.push_back('{1'b0, 1'b0, 1'b0, GAP2});
      v.push_back('{1'b0, 1'b0, 1'b0, GAP2});
      foreach (v[i]) begin
         step(v[i]);
         want = exp_q.pop_front();
         vectors++;
         if (obs() !== want) begin
            $display("FAIL tie_handover[%0d]: got %b want %b", i, obs(), want);
            miscompares++;
         end
      end
   endtask

   // Both masters keep requesting; the owner releases for one edge after 4 grant cycles.
   task automatic test_back_to_back();
      vec_t v[$];
      logic [4:0] want;
      logic prev_m1;
      for (int i = 0; i < 4; i++) v.push_back('{1'b0, 1'b1, 1'b1, G1});
      prev_m1 = 1'b1;
      for (int r = 1; r <= 4; r++) begin
         v.push_back('{1'b0, !prev_m1, prev_m1, prev_m1 ? RST_V : GAP2});
         v.push_back('{1'b0, 1'b1, 1'b1, prev_m1 ? RST_V : GAP2});
         for (int i = 0; i < 4; i++) v.push_back('{1'b0, 1'b1, 1'b1, prev_m1 ? G2 : G1});
         prev_m1 = !prev_m1;
      end
      v.push_back('{1'b0, 1'b0, 1'b0, RST_V});
      v.push_back('{1'b0, 1'b0, 1'b0, RST_V});
      v.push_back('{1'b0, 1'b0, 1'b0, RST_V});
      foreach (v[i]) begin
         step(v[i]);
         want = exp_q.pop_front();
         vectors++;
         if (obs() !== want) begin
            $display("FAIL back_to_back[%0d]: got %b want %b", i, obs(), want);
            miscompares++;
         end
      end
   endtask

   task automatic test_hold_limit();
      vec_t v[$];
      logic [4:0] want;
`ifdef ARB_TIMEOUT_EN
      for (int i = 0; i < MH; i++) v.push_back('{1'b0, 1'b0, 1'b1, G2});
      v.push_back('{1'b0, 1'b0, 1'b1, TOUT2});
      v.push_back('{1'b0, 1'b0, 1'b1, GAP2});
      v.push_back('{1'b0, 1'b0, 1'b1, G2});
`else
      for (int i = 0; i < 3 * MH; i++) v.push_back('{1'b0, 1'b0, 1'b1, G2});
`endif
      v.push_back('{1'b0, 1'b0, 1'b0, GAP2});
      v.push_back('{1'b0, 1'b0, 1'b0, GAP2});
      v.push_back('{1'b0, 1'b0, 1'b0, GAP2});
      foreach (v[i]) begin
         step(v[i]);
         want = exp_q.pop_front();
         vectors++;
         if (obs() !== want) begin
            $display("FAIL hold_limit[%0d]: got %b want %b", i, obs(), want);
            miscompares++;
         end
      end
   endtask

   // Reset while master 2 owns the bus, then again mid-turnaround; master 1 must win each later tie.
   task automatic test_reset_mid();
      vec_t v[$];
      logic [4:0] want;
      v.push_back('{1'b0, 1'b0, 1'b1, G2});
      v.push_back('{1'b0, 1'b0, 1'b1, G2});
      v.push_back('{1'b1, 1'b0, 1'b1, RST_V});
      v.push_back('{1'b0, 1'b1, 1'b1, G1});
      v.push_back('{1'b0, 1'b0, 1'b1, RST_V});
      v.push_back('{1'b1, 1'b0, 1'b1, RST_V});
      v.push_back('{1'b0, 1'b1, 1'b1, G1});
      v.push_back('{1'b0, 1'b0, 1'b0, RST_V});
      v.push_back('{1'b0, 1'b0, 1'b0, RST_V});
      v.push_back('{1'b0, 1'b0, 1'b0, RST_V});
      foreach (v[i]) begin
         step(v[i]);
         want = exp_q.pop_front();
         vectors++;
         if (obs() !== want) begin
            $display("FAIL reset_mid[%0d]: got %b want %b", i, obs(), want);
            miscompares++;
         end
      end
   endtask

   initial begin
      rst  = 1'b1;
      req1 = 1'b0;
      req2 = 1'b0;
      test_reset();
      test_grant_latency();
      test_tie_handover();
      test_back_to_back();
      test_hold_limit();
      test_reset_mid();
      if (exp_q.size() != 0) begin
         $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
         miscompares++;
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Two-master bus arbiter for the ADS bus that generates `master_select` for `control_mux_n_decoder`. It accepts request/hold handshakes from master 1 and master 2 and grants the shared bus to one master at a time, with round-robin fairness on simultaneous requests. On every ownership change it inserts a dead turnaround so the 2-cycle mux/decoder pipeline drains before the other master drives the bus.

## Interface
Parameters:
- `TURNAROUND`, default 2: dead cycles, both grants low, between consecutive grants. Legal range ≥1.
- `MAX_HOLD`, default 64: maximum consecutive grant cycles per ownership. Used only with `ARB_TIMEOUT_EN`. Legal range ≥2.
- `CNT_W`, default 7: shared counter width. Must satisfy 2^CNT_W > max(`TURNAROUND`, `MAX_HOLD`).

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req1`  in  1  master 1 requests the bus. The master holds it high for the whole transaction; dropping it releases the bus.
- `req2`  in  1  master 2, same semantics.
- `grant1`  out  1  master 1 owns the bus. Registered.
- `grant2`  out  1  master 2 owns the bus. Registered.
- `master_select`  out  1  drives the mux: 1 = master 1, 0 = master 2. Registered. Holds the last owner while idle or in turnaround.
- `bus_busy`  out  1  equals `grant1 | grant2`. Registered.
- `timeout_err`  out  1  one-cycle pulse when a grant is forcibly revoked. Constant 0 without `ARB_TIMEOUT_EN`.

## Operation
- States: IDLE, GNT1, GNT2, TURN. The block also keeps a `last_owner` register and one counter `cnt` of `CNT_W` bits.
- Reset values: state = IDLE, `grant1` = 0, `grant2` = 0, `master_select` = 1, `bus_busy` = 0, `timeout_err` = 0, `cnt` = 0, `last_owner` = master 2. As a result, master 1 wins the first tie.
- Arbitration (evaluated in IDLE, and on TURN exit):
  - Only `req1` high → GNT1.
  - Only `req2` high → GNT2.
  - Both high → the master that is not `last_owner`.
  - Neither high → IDLE.
- Entering GNTx sets `grantx` = 1, sets `master_select` to x, and clears `cnt`.
- GNTx, `reqx` sampled low → TURN. In the same edge: `grantx` = 0, `last_owner` = x, `cnt` = 0.
- GNTx, `reqx` still high → stay in GNTx.
- TURN:
  - Both grants are low and `master_select` is unchanged.
  - If `cnt` == `TURNAROUND`-1, arbitrate (to GNT1, GNT2 or IDLE).
  - Otherwise `cnt` increments.
- A request that arrives during TURN waits for TURN exit. Requests are level-sensitive; nothing is latched.
- Both grants are never high in the same cycle.
- A synchronous `rst` mid-grant or mid-TURN returns every output to its reset value at that edge and discards the in-flight ownership.

## Timing
- Grant latency: `reqx` sampled high at edge k in IDLE → `grantx` and `master_select` valid after edge k (1 cycle).
- Release: `reqx` sampled low at edge n → `grantx` low after edge n.
- Next grant is possible after edge n+`TURNAROUND`, so the bus-idle gap is exactly `TURNAROUND` cycles.
- `master_select` changes only on the edge that asserts a grant. It never toggles while either grant is high.
- Back-to-back handover with both requesting and `TURNAROUND`=2: grant1 low at edge n, grant2 high after edge n+2.

## Configuration
- Macro: `ARB_TIMEOUT_EN`.
- Defined:
  - In GNTx with `reqx` high, `cnt` increments each edge.
  - At the edge where `cnt` == `MAX_HOLD`-1, the block revokes: enters TURN, drops `grantx`, sets `last_owner` = x, and pulses `timeout_err` for one cycle.
  - The grant therefore lasts exactly `MAX_HOLD` cycles.
  - After TURN, normal arbitration applies. A still-requesting revoked master loses to a requesting peer but regains the bus if the peer is idle.
- Undefined: no hold limit. A grant persists as long as `reqx` stays high. `timeout_err` is tied to 0.

## Test plan
- Reset, then `req1`=1 at edge 3 → `grant1`=1 and `master_select`=1 after edge 3; `grant2`=0 throughout.
- `req1`=`req2`=1 from idle after reset → master 1 is granted first. Drop `req1` at edge 10 → `grant1`=0 after edge 10, `grant2`=1 and `master_select`=0 after edge 12; no cycle with both grants high.
- Repeated simultaneous requests with each master releasing after 4 cycles → grants strictly alternate 1,2,1,2, with exactly a 2-cycle gap each time.
- `ARB_TIMEOUT_EN`, `MAX_HOLD`=8, `req2` held high with `req1` low → `grant2` high for exactly 8 cycles, `timeout_err` pulses for 1 cycle, then after 2 idle cycles `grant2` is re-granted.
- Assert `rst` for one cycle while `grant2`=1 and while in TURN → at that edge all outputs return to reset values. With both `req1` and `req2` high afterwards, master 1 wins.
